// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the two-digit seven-segment scan controller:
// FSM state encoding, segment constants and the digit enable table.
package seg7_scan_ctrl_pkg;

    localparam int SEG_W = 7;
    localparam int DIG_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // All segments dark before polarity is applied
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // One-hot digit enable for the digit currently selected on the mux
    function automatic logic [DIG_N-1:0] digit_onehot(input logic sel);
        logic [DIG_N-1:0] dig;
        case (sel)
            1'b0:    dig = 2'b01;
            1'b1:    dig = 2'b10;
            default: dig = 2'b00;
        endcase
        return dig;
    endfunction

    // Applies output polarity to a segment pattern
    function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] pat,
                                                   input logic             pol);
        return pat ^ {SEG_W{pol}};
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side signal bundle of the scan controller. The master side feeds
// the scan enable and the mux output; the slave side (the controller) drives
// the mux select, the segment pins, the digit enables and busy.
interface seg7_scan_ctrl_if;
    import seg7_scan_ctrl_pkg::*;

    logic             en;
    logic [SEG_W-1:0] seg_in;
    logic             sel;
    logic [SEG_W-1:0] seg_out;
    logic [DIG_N-1:0] dig_en;
    logic             busy;

    modport master (
        output en,
        output seg_in,
        input  sel,
        input  seg_out,
        input  dig_en,
        input  busy
    );

    modport slave (
        input  en,
        input  seg_in,
        output sel,
        output seg_out,
        output dig_en,
        output busy
    );

endinterface

// File: rtl/seg7_scan_counter.sv
// Parameterised wrapping up-counter with synchronous clear and a
// terminal-count flag. Used both as the refresh prescaler and as the
// blanking-gap counter.
module seg7_scan_counter #(
    parameter int WIDTH = 16,
    parameter int MAX   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_r;

    // Count 0..MAX while enabled, wrap at MAX, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            if (count_r == MAX_V) begin
                count_r <= {WIDTH{1'b0}};
            end else begin
                count_r <= count_r + WIDTH'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal count: the cycle in which an enabled count reaches MAX
    always_comb begin
        tc = en & ~clr & (count_r == MAX_V);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexing controller for a two-digit seven-segment display.
// Each digit gets a blanking gap of BLANK_CYC cycles (mux settles, nothing
// lit) followed by DIV_MAX+1 cycles of display. The mux select only moves
// when leaving SHOW, so it is always stable while any digit is enabled.
// Legal ranges: DIV_MAX 1..2^DIV_W-1, BLANK_CYC 1..15.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DIV_MAX   = 49999,
    parameter int BLANK_CYC = 4,
    parameter bit SEG_POL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_ctrl_if.slave      bus
);

    // Segment value that leaves every segment dark at the pins
    localparam logic [SEG_W-1:0] SEG_DARK = seg_drive(SEG_OFF, SEG_POL);

    state_t           state_r;
    logic             sel_r;
    logic [SEG_W-1:0] seg_out_r;
    logic [DIG_N-1:0] dig_en_r;
    logic             busy_r;

    logic             div_en_s;
    logic             div_clr_s;
    logic             div_tc_s;
    logic             blank_en_s;
    logic             blank_clr_s;
    logic             blank_tc_s;

    // Counters run only in their own state and are cleared elsewhere or when scanning stops
    always_comb begin
        div_en_s    = (state_r == ST_SHOW);
        div_clr_s   = ~bus.en | (state_r != ST_SHOW);
        blank_en_s  = (state_r == ST_BLANK);
        blank_clr_s = ~bus.en | (state_r != ST_BLANK);
    end

    seg7_scan_counter #(
        .WIDTH (DIV_W),
        .MAX   (DIV_MAX)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr_s),
        .en    (div_en_s),
        .tc    (div_tc_s)
    );

    seg7_scan_counter #(
        .WIDTH (4),
        .MAX   (BLANK_CYC - 1)
    ) u_blank_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (blank_clr_s),
        .en    (blank_en_s),
        .tc    (blank_tc_s)
    );

    // Scan FSM with registered select, segment and digit-enable outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sel_r     <= 1'b0;
            seg_out_r <= SEG_DARK;
            dig_en_r  <= 2'b00;
            busy_r    <= 1'b0;
        end else if (!bus.en) begin
            // Dropping the enable always wins: go dark and forget the phase
            state_r   <= ST_IDLE;
            sel_r     <= 1'b0;
            seg_out_r <= SEG_DARK;
            dig_en_r  <= 2'b00;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Every restart begins at digit0 with a full blanking gap
                    state_r   <= ST_BLANK;
                    sel_r     <= 1'b0;
                    seg_out_r <= SEG_DARK;
                    dig_en_r  <= 2'b00;
                    busy_r    <= 1'b1;
                end
                ST_BLANK: begin
                    sel_r  <= sel_r;
                    busy_r <= 1'b1;
                    if (blank_tc_s) begin
                        // Mux has settled on the selected digit: light it
                        state_r   <= ST_SHOW;
                        seg_out_r <= seg_drive(bus.seg_in, SEG_POL);
                        dig_en_r  <= digit_onehot(sel_r);
                    end else begin
                        state_r   <= ST_BLANK;
                        seg_out_r <= SEG_DARK;
                        dig_en_r  <= 2'b00;
                    end
                end
                ST_SHOW: begin
                    busy_r <= 1'b1;
                    if (div_tc_s) begin
                        // Switch digits behind a dark gap so nothing ghosts
                        state_r   <= ST_BLANK;
                        sel_r     <= ~sel_r;
                        seg_out_r <= SEG_DARK;
                        dig_en_r  <= 2'b00;
                    end else begin
                        state_r   <= ST_SHOW;
                        sel_r     <= sel_r;
                        seg_out_r <= seg_drive(bus.seg_in, SEG_POL);
                        dig_en_r  <= digit_onehot(sel_r);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    sel_r     <= 1'b0;
                    seg_out_r <= SEG_DARK;
                    dig_en_r  <= 2'b00;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel     = sel_r;
    assign bus.seg_out = seg_out_r;
    assign bus.dig_en  = dig_en_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIV_MAX=9, BLANK_CYC=2, SEG_POL=0.
// Directed table, reset corner cases, then random en/seg_in against a
// frame-position reference model.
module tb_seg7_scan_ctrl;

    localparam int B     = 2;
    localparam int D     = 9;
    localparam int HALF  = B + D + 1;
    localparam int FRAME = 2 * HALF;

    logic clk;
    logic rst_n;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .DIV_W     (16),
        .DIV_MAX   (D),
        .BLANK_CYC (B),
        .SEG_POL   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: number of consecutive clock edges with en high since
    // reset or the last en-low edge, plus the seg_in seen at the last edge.
    int         k = 0;
    logic [6:0] seg_smp = 7'h00;

    // Model state update
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 0;
            seg_smp <= 7'h00;
        end else begin
            k       <= bus.en ? k + 1 : 0;
            seg_smp <= bus.seg_in;
        end
    end

    // Expected outputs from the position inside the 24-cycle frame
    function automatic void model_exp(input int kk, input logic [6:0] smp,
                                      output logic e_sel, output logic [1:0] e_dig,
                                      output logic [6:0] e_seg, output logic e_busy);
        int p;
        int h;
        int q;
        if (kk == 0) begin
            e_sel = 1'b0; e_dig = 2'b00; e_seg = 7'h00; e_busy = 1'b0;
        end else begin
            p      = (kk - 1) % FRAME;
            h      = p / HALF;
            q      = p % HALF;
            e_sel  = (h == 1);
            e_busy = 1'b1;
            if (q < B) begin
                e_dig = 2'b00;
                e_seg = 7'h00;
            end else begin
                e_dig = (h == 1) ? 2'b10 : 2'b01;
                e_seg = smp;
            end
        end
    endfunction

    typedef struct {
        logic       en;
        logic [6:0] seg;
        int         n;
        logic       sel;
        logic [1:0] dig;
        logic [6:0] sout;
        logic       busy;
    } vec_t;

    vec_t vec [10];

    task automatic check_outs(input string tag, input logic e_sel, input logic [1:0] e_dig,
                              input logic [6:0] e_seg, input logic e_busy);
        check({tag, ".sel"},     32'(bus.sel),     32'(e_sel));
        check({tag, ".dig_en"},  32'(bus.dig_en),  32'(e_dig));
        check({tag, ".seg_out"}, 32'(bus.seg_out), 32'(e_seg));
        check({tag, ".busy"},    32'(bus.busy),    32'(e_busy));
    endtask

    logic       m_sel;
    logic [1:0] m_dig;
    logic [6:0] m_seg;
    logic       m_busy;
    logic       prev_sel;
    logic [1:0] prev_dig;

    initial begin
        // en, seg_in, cycles, expected sel, dig_en, seg_out, busy
        vec[0] = '{1'b0, 7'h00, 2,  1'b0, 2'b00, 7'h00, 1'b0};
        vec[1] = '{1'b1, 7'h06, 2,  1'b0, 2'b00, 7'h00, 1'b1};
        vec[2] = '{1'b1, 7'h3F, 5,  1'b0, 2'b01, 7'h3F, 1'b1};
        vec[3] = '{1'b1, 7'h66, 5,  1'b0, 2'b01, 7'h66, 1'b1};
        vec[4] = '{1'b1, 7'h5B, 2,  1'b1, 2'b00, 7'h00, 1'b1};
        vec[5] = '{1'b1, 7'h4F, 5,  1'b1, 2'b10, 7'h4F, 1'b1};
        vec[6] = '{1'b0, 7'h4F, 3,  1'b0, 2'b00, 7'h00, 1'b0};
        vec[7] = '{1'b1, 7'h06, 2,  1'b0, 2'b00, 7'h00, 1'b1};
        vec[8] = '{1'b1, 7'h6D, 10, 1'b0, 2'b01, 7'h6D, 1'b1};
        vec[9] = '{1'b1, 7'h7F, 2,  1'b1, 2'b00, 7'h00, 1'b1};

        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.seg_in = 7'h00;

        // Held in reset while inputs wiggle: everything stays dark
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_outs("reset", 1'b0, 2'b00, 7'h00, 1'b0);
            bus.en     = ~bus.en;
            bus.seg_in = 7'($urandom);
        end
        bus.en     = 1'b0;
        bus.seg_in = 7'h00;
        rst_n      = 1'b1;

        // Directed scan sequence: start, both digits, en drop, restart
        for (int r = 0; r < 10; r++) begin
            bus.en     = vec[r].en;
            bus.seg_in = vec[r].seg;
            for (int c = 0; c < vec[r].n; c++) begin
                @(negedge clk);
                check_outs($sformatf("vec%0d_%0d", r, c), vec[r].sel, vec[r].dig,
                           vec[r].sout, vec[r].busy);
            end
        end

        // Asynchronous reset in the middle of digit1 SHOW
        bus.en     = 1'b1;
        bus.seg_in = 7'h1C;
        repeat (3) @(negedge clk);
        check_outs("pre_rst", 1'b1, 2'b10, 7'h1C, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 2'b00, 7'h00, 1'b0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs("post_rst_idle", 1'b0, 2'b00, 7'h00, 1'b0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        check_outs("restart", 1'b0, 2'b00, 7'h00, 1'b1);

        // Random en and seg_in against the frame model plus invariants
        prev_sel = bus.sel;
        prev_dig = bus.dig_en;
        for (int i = 0; i < 10000; i++) begin
            bus.en     = ($urandom_range(0, 99) != 0);
            bus.seg_in = 7'($urandom);
            @(negedge clk);
            model_exp(k, seg_smp, m_sel, m_dig, m_seg, m_busy);
            check_outs("rnd", m_sel, m_dig, m_seg, m_busy);
            check("inv_not_both", 32'(bus.dig_en != 2'b11), 32'd1);
            if (bus.dig_en == 2'b00) begin
                check("inv_dark", 32'(bus.seg_out), 32'd0);
            end
            if (bus.dig_en != 2'b00 && prev_dig != 2'b00) begin
                check("inv_sel_stable", 32'(bus.sel), 32'(prev_sel));
            end
            prev_sel = bus.sel;
            prev_dig = bus.dig_en;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
